// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding,
// FSM state type and datapath width.
package mips_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } md_state_e;

  // Magnitude of v when it is to be read as signed; pass-through otherwise.
  function automatic logic [DATA_W-1:0] mag(input logic sgn, input logic [DATA_W-1:0] v);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
// quotient/remainder show the result *after* the current step, so the final
// step's result can be captured on the same edge that performs it.
module div_core
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] quo, rem, dvs;
  logic [DATA_W:0]   shifted;
  logic              ge;

  // Partial remainder can reach 33 bits before the trial subtract.
  assign shifted   = {rem, quo[DATA_W-1]};
  assign ge        = shifted >= {1'b0, dvs};
  assign remainder = ge ? DATA_W'(shifted - {1'b0, dvs}) : shifted[DATA_W-1:0];
  assign quotient  = {quo[DATA_W-2:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      quo <= quotient;
      rem <= remainder;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit beside EX: multi-cycle MULT/DIV with pipeline
// stall request, MTHI/MTLO, and architectural HI/LO registers.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int MUL_LAT   = 2,
  parameter int DIV_ITERS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              stall_req,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy
);

  md_state_e state, state_nxt;

  logic [4:0]          cnt;
  logic [DATA_W-1:0]   op_a, op_b;
  logic                mul_sgn, neg_q, neg_r;
  logic                is_mul, is_div, div_sgn, issue;
  logic                mul_last, div_last;
  logic                div_load, div_step;
  logic [2*DATA_W-1:0] ext_a, ext_b, prod;
  logic [DATA_W-1:0]   quo, rem;

  assign is_mul   = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div   = (op == MD_DIV)  || (op == MD_DIVU);
  assign div_sgn  = (op == MD_DIV);
  assign issue    = (state == S_IDLE) && start && !flush;
  assign mul_last = (state == S_MUL) && (cnt == 5'(MUL_LAT - 1));
  assign div_last = (state == S_DIV) && (cnt == 5'(DIV_ITERS - 1));
  assign busy     = (state != S_IDLE);

  // Operands are latched, so a single wide multiply over the MUL cycles
  // stands in for a pipelined multiplier.
  assign ext_a = mul_sgn ? {{DATA_W{op_a[DATA_W-1]}}, op_a} : {{DATA_W{1'b0}}, op_a};
  assign ext_b = mul_sgn ? {{DATA_W{op_b[DATA_W-1]}}, op_b} : {{DATA_W{1'b0}}, op_b};
  assign prod  = ext_a * ext_b;

  assign div_load = issue && is_div && (rt_val != '0);
  assign div_step = (state == S_DIV) && !flush;

  div_core u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag(div_sgn, rs_val)),
    .divisor   (mag(div_sgn, rt_val)),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_req = 1'b0;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && is_mul) begin
            state_nxt = S_MUL;
            stall_req = 1'b1;
          end else if (start && is_div) begin
            // Zero divisor: one stall cycle, then DONE with HI/LO untouched.
            state_nxt = (rt_val == '0) ? S_DONE : S_DIV;
            stall_req = 1'b1;
          end
        end
        S_MUL: begin
          stall_req = 1'b1;
          if (mul_last) state_nxt = S_DONE;
        end
        S_DIV: begin
          stall_req = 1'b1;
          if (div_last) state_nxt = S_DONE;
        end
        S_DONE: begin
          // start is ignored here so the held instruction is not re-run.
          if (!ex_hold) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      mul_sgn <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= '0;
            if (is_mul) begin
              op_a    <= rs_val;
              op_b    <= rt_val;
              mul_sgn <= (op == MD_MULT);
            end
            if (is_div) begin
              neg_q <= div_sgn && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
              neg_r <= div_sgn && rs_val[DATA_W-1];
            end
            if (op == MD_MTHI) hi <= rs_val;
            if (op == MD_MTLO) lo <= rs_val;
          end
        end
        S_MUL: begin
          cnt <= cnt + 5'd1;
          if (mul_last) {hi, lo} <= prod;
        end
        S_DIV: begin
          cnt <= cnt + 5'd1;
          if (div_last) begin
            lo <= neg_q ? -quo : quo;
            hi <= neg_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: cycle-level reference model plus literal checks.
module tb_muldiv_unit;
  import mips_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        ex_hold = 1'b0;
  logic        flush = 1'b0;
  logic        stall_req, busy;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.MUL_LAT(MUL_LAT), .DIV_ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .ex_hold(ex_hold), .flush(flush), .stall_req(stall_req),
    .hi(hi), .lo(lo), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining stall cycles, a done flag and the pending result.
  int          m_left;
  bit          m_done;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        long_op, exp_stall, exp_busy;

  assign long_op   = op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  assign exp_stall = !flush && ((m_left > 0) || (!m_done && start && long_op));
  assign exp_busy  = (m_left > 0) || m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0;
    end else if (flush) begin
      m_left <= 0; m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
      end
    end else if (m_done) begin
      if (!ex_hold) m_done <= 1'b0;
    end else if (start) begin
      case (op)
        MD_MULT: begin
          {p_hi, p_lo} <= 64'(longint'($signed(rs_val)) * longint'($signed(rt_val)));
          m_left <= MUL_LAT;
        end
        MD_MULTU: begin
          {p_hi, p_lo} <= {32'b0, rs_val} * {32'b0, rt_val};
          m_left <= MUL_LAT;
        end
        MD_DIV: begin
          if (rt_val == 0) m_done <= 1'b1;
          else begin
            p_lo <= 32'(longint'($signed(rs_val)) / longint'($signed(rt_val)));
            p_hi <= 32'(longint'($signed(rs_val)) % longint'($signed(rt_val)));
            m_left <= 32;
          end
        end
        MD_DIVU: begin
          if (rt_val == 0) m_done <= 1'b1;
          else begin
            p_lo <= rs_val / rt_val;
            p_hi <= rs_val % rt_val;
            m_left <= 32;
          end
        end
        MD_MTHI: m_hi <= rs_val;
        MD_MTLO: m_lo <= rs_val;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_stall", stall_req, exp_stall);
      check("cyc_busy", busy, exp_busy);
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  // Issue a long op, count stall cycles, optionally hold EX in DONE.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input int exp_stalls,
                        input logic [63:0] exp_hilo);
    int n;
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_val = a; rt_val = b; ex_hold = (hold > 0);
    n = 0;
    @(negedge clk);
    while (stall_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_stalls"}, 64'(n), 64'(exp_stalls));
    check({name, "_done_busy"}, busy, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_held"}, {stall_req, busy}, 2'b01);
    end
    ex_hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE;
    @(negedge clk);
    check({name, "_hilo"}, {hi, lo}, exp_hilo);
    check({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_val = v;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_stall_busy", {stall_req, busy}, 2'b00);
    rst_n = 1'b1;

    run_op("mult",  MD_MULT,  32'hFFFFFFFF, 32'h2, 0, 3,  64'hFFFFFFFF_FFFFFFFE);
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'h2, 0, 3,  64'h00000001_FFFFFFFE);
    run_op("divu",  MD_DIVU,  32'd100,      32'd7, 0, 33, {32'd2, 32'd14});
    run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 0, 33, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 33, 64'h00000000_80000000);

    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);
    @(negedge clk);
    check("mt_hilo", {hi, lo}, 64'h00000011_00000022);
    run_op("div0", MD_DIV, 32'd55, 32'd0, 0, 1, 64'h00000011_00000022);

    // Flush a DIVU at iteration 10.
    @(posedge clk); #1;
    start = 1'b1; op = MD_DIVU; rs_val = 32'd100; rt_val = 32'd7;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_stall", stall_req, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0; op = MD_NONE;
    @(negedge clk);
    check("flush_idle", {stall_req, busy}, 2'b00);
    check("flush_hilo", {hi, lo}, 64'h00000011_00000022);

    run_op("mult34", MD_MULT, 32'd3, 32'd4, 0, 3, 64'd12);
    run_op("mult_hold", MD_MULT, 32'd7, 32'd6, 4, 3, 64'd42);

    // MTLO killed by a coincident flush.
    @(posedge clk); #1;
    start = 1'b1; op = MD_MTLO; rs_val = 32'hDEAD; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE; flush = 1'b0;
    @(negedge clk);
    check("mtlo_flush", lo, 32'd42);

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    start = 1'b1; op = MD_DIVU; rs_val = 32'd1000; rt_val = 32'd3;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0; start = 1'b0; op = MD_NONE;
    @(negedge clk);
    check("midrst_hilo", {hi, lo}, 64'h0);
    check("midrst_stall_busy", {stall_req, busy}, 2'b00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle HI/LO arithmetic unit sitting beside the EX stage of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO, holds the architectural HI/LO registers, and feeds them to MFHI/MFLO.
- Raises `stall_req` toward the pipeline stall controller while an operation is in flight. It is the requesting end of the stall interface.

Parameters:
- MUL_LAT, 2, cycles spent in the MUL state (legal 1..4); models a pipelined multiplier.
- DIV_ITERS, 32, radix-2 divide iterations; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX holds a valid HI/LO op this cycle; held high while EX is stalled.
- op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
- rs_val  in  32  operand A (dividend / multiplicand / MTHI-MTLO source).
- rt_val  in  32  operand B (divisor / multiplier).
- ex_hold  in  1  EX is stalled by another source; the instruction stays in EX.
- flush  in  1  kill the EX instruction (exception / branch redirect).
- stall_req  out  1  request to the stall controller to hold IF/ID/EX.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.
- busy  out  1  state is not IDLE (debug/perf).

Behaviour:
- Reset values: state IDLE, hi=0, lo=0, counter=0, stall_req=0, busy=0.
- States are IDLE, MUL, DIV, DONE.
- IDLE:
  - start && MULT/MULTU: latch operands, go to MUL, counter=0.
  - start && DIV/DIVU with rt_val!=0: latch operand magnitudes and sign flags, go to DIV, counter=0.
  - start && DIV/DIVU with rt_val==0: go directly to DONE. HI/LO unchanged; no trap.
  - start && MTHI: hi<=rs_val at this edge; no state change; no stall.
  - start && MTLO: lo<=rs_val at this edge; no state change; no stall.
- MUL:
  - Counter increments each cycle.
  - At the edge where counter==MUL_LAT-1, write {hi,lo} <= 64-bit product and go to DONE.
  - MULT is a signed 32x32 multiply; MULTU is unsigned.
- DIV:
  - Restoring division, one quotient bit per cycle.
  - At the edge where counter==31, write lo<=quotient and hi<=remainder (sign-corrected), and go to DONE.
  - Signed rule: quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (wraps, no exception).
- DONE:
  - stall_req=0, so the instruction can leave EX.
  - start is ignored in DONE; this prevents re-execution of the held instruction.
  - Stay in DONE while ex_hold=1. Go to IDLE when ex_hold=0.
- stall_req (combinational):
  - 1 when state is MUL or DIV.
  - 1 when state is IDLE && start && op is MULT/MULTU/DIV/DIVU && !flush. This includes DIV/DIVU with zero divisor, which stalls for 1 cycle.
  - 0 otherwise.
- Stall totals: MUL 1+MUL_LAT cycles (3 by default); DIV 33 cycles.
- flush:
  - Has priority over everything.
  - Any state goes to IDLE next edge with no HI/LO write.
  - stall_req=0 in the flush cycle.
  - A flush coincident with the final MUL/DIV edge suppresses the write.
  - A flush coincident with MTHI/MTLO suppresses the write.
- hi/lo are registered. MFHI/MFLO issued in the cycle after DONE see new values; the forwarding path is not required.
- Reset mid-operation: immediate return to reset values; any partial result is discarded.

Decomposition:
- Shared package mips_pkg holds:
  - the op encoding constants (MD_NONE..MD_MTLO);
  - the muldiv state enum;
  - the DATA_W=32 constant.
- One natural sub-module: div_core. It is the iterative restoring divider with a load pulse, a 32-cycle shift/subtract datapath, and quotient/remainder outputs. Sign handling, the multiplier, the FSM and HI/LO stay in muldiv_unit.

Test Plan:
- MULT rs=0xFFFFFFFF rt=0x00000002 -> stall_req high 3 cycles; hi=0xFFFFFFFF lo=0xFFFFFFFE; DONE lasts 1 cycle with stall_req=0.
- MULTU with the same operands -> hi=0x00000001 lo=0xFFFFFFFE.
- DIVU rs=100 rt=7 -> stall_req high 33 consecutive cycles; lo=14 hi=2.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV rt=0 with hi/lo preloaded 0x11/0x22 via MTHI/MTLO -> stall 1 cycle; hi/lo unchanged.
- DIVU in progress, flush at iteration 10 -> IDLE next cycle, stall_req=0, hi/lo unchanged.
- A follow-up MULT 3*4 -> lo=12 hi=0.
- MULT completes while ex_hold=1 for 4 cycles with start still high -> unit stays in DONE, no re-execution; hi/lo written exactly once.
